// File: rtl/riscv_icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package riscv_icache_pkg;

  localparam int BEAT_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_REQ     = 3'd2,
    ST_REFILL  = 3'd3,
    ST_RESPOND = 3'd4
  } state_e;

  // Byte-offset bits within a line (beat select plus 3 bits of byte-in-beat).
  function automatic int offset_w(input int line_beats);
    return $clog2(line_beats) + 3;
  endfunction

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int line_beats);
    return 32 - offset_w(line_beats) - index_w(lines);
  endfunction

endpackage

// File: rtl/riscv_icache_data_array.sv
// Line storage with tag/valid arrays: one refill write port, one lookup read
// port, and a bulk valid clear for fence.i.
module riscv_icache_data_array
  import riscv_icache_pkg::*;
#(
  parameter  int LINES      = 64,
  parameter  int LINE_BEATS = 4,
  localparam int IDX_W      = index_w(LINES),
  localparam int BI_W       = offset_w(LINE_BEATS) - 3,
  localparam int TAG_W      = tag_w(LINES, LINE_BEATS)
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              i_clr_valid,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_w_idx,
  input  logic [BI_W-1:0]   i_w_beat,
  input  logic [BEAT_W-1:0] i_w_data,
  input  logic              i_tag_we,
  input  logic [TAG_W-1:0]  i_w_tag,
  input  logic [IDX_W-1:0]  i_r_idx,
  input  logic [BI_W-1:0]   i_r_beat,
  output logic [BEAT_W-1:0] o_r_data,
  output logic [TAG_W-1:0]  o_r_tag,
  output logic              o_r_valid
);

  logic [BEAT_W-1:0] r_data  [LINES*LINE_BEATS];
  logic [TAG_W-1:0]  r_tag   [LINES];
  logic [LINES-1:0]  r_valid;

  // Refill beats and line tags; contents are don't-care until the valid bit is set.
  always_ff @(posedge clk) begin
    if (i_we) r_data[{i_w_idx, i_w_beat}] <= i_w_data;
    if (i_tag_we) r_tag[i_w_idx] <= i_w_tag;
  end

  // Valid bits: clear beats set so an invalidate on the completion edge also kills the new line.
  always_ff @(posedge clk) begin
    if (!srst_n) r_valid <= '0;
    else if (i_clr_valid) r_valid <= '0;
    else if (i_tag_we) r_valid[i_w_idx] <= 1'b1;
  end

  assign o_r_data  = r_data[{i_r_idx, i_r_beat}];
  assign o_r_tag   = r_tag[i_r_idx];
  assign o_r_valid = r_valid[i_r_idx];

endmodule

// File: rtl/riscv_icache.sv
// Direct-mapped instruction cache, responder side of the fetch handshake.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no request outstanding, accepting
// ST_LOOKUP  | tag compare for latched pc; hit answers this cycle
// ST_REQ     | line read request held on mem_req until granted
// ST_REFILL  | collecting LINE_BEATS beats into the indexed line
// ST_RESPOND | answering the missed request from the refilled line
module riscv_icache
  import riscv_icache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_BEATS = 4
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              i_icache_read_request,
  input  logic [31:0]       i_icache_pc,
  input  logic              i_icache_flush,
  output logic              o_icache_accept,
  output logic              o_icache_data_valid,
  output logic [BEAT_W-1:0] o_icache_inst,
  input  logic              i_icache_invalidate,
  output logic              o_mem_req,
  output logic [31:0]       o_mem_addr,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [BEAT_W-1:0] i_mem_rdata
);

  localparam int OFF_W = offset_w(LINE_BEATS);
  localparam int IDX_W = index_w(LINES);
  localparam int TAG_W = tag_w(LINES, LINE_BEATS);
  localparam int BI_W  = OFF_W - 3;

  state_e            r_state;
  logic [31:3]       r_pc;
  logic [31:3]       r_pend_pc;
  logic              r_pend;
  logic              r_skip;
  logic              r_pend_inv;
  logic [BI_W-1:0]   r_cnt;

  logic [IDX_W-1:0]  w_idx;
  logic [BI_W-1:0]   w_beat;
  logic [TAG_W-1:0]  w_tag;
  logic [BEAT_W-1:0] w_rdata;
  logic [TAG_W-1:0]  w_rtag;
  logic              w_rvalid;
  logic              w_hit;
  logic              w_take;
  logic              w_filling;
  logic              w_last;
  logic              w_pend_nxt;
  logic [31:3]       w_pend_pc_nxt;
  logic              w_skip_nxt;
  logic              w_clr;
  logic              w_unused;

  assign w_unused  = &{1'b0, i_icache_pc[2:0]};

  assign w_idx     = r_pc[OFF_W +: IDX_W];
  assign w_beat    = r_pc[OFF_W-1:3];
  assign w_tag     = r_pc[31 -: TAG_W];
  assign w_hit     = w_rvalid && (w_rtag == w_tag);
  assign w_filling = (r_state == ST_REQ) || (r_state == ST_REFILL);
  assign w_last    = (r_state == ST_REFILL) && i_mem_rvalid && (r_cnt == BI_W'(LINE_BEATS - 1));

  // Accept never looks at the request itself; flush always opens the door for the redirect pc.
  assign o_icache_accept = srst_n && ((r_state == ST_IDLE) ||
                                      ((r_state == ST_LOOKUP) && w_hit) ||
                                      i_icache_flush);
  assign w_take = o_icache_accept && i_icache_read_request;

  assign o_icache_data_valid = (((r_state == ST_LOOKUP) && w_hit) || (r_state == ST_RESPOND)) &&
                               !i_icache_flush;
  assign o_icache_inst = o_icache_data_valid ? w_rdata : '0;

  assign o_mem_req  = (r_state == ST_REQ);
  assign o_mem_addr = (r_state == ST_REQ) ? {r_pc[31:OFF_W], {OFF_W{1'b0}}} : 32'd0;

  // A flush during refill redirects: the newest flush wins, and one without a request drops the pending pc.
  assign w_pend_nxt    = i_icache_flush ? i_icache_read_request : r_pend;
  assign w_pend_pc_nxt = i_icache_flush ? i_icache_pc[31:3] : r_pend_pc;
  assign w_skip_nxt    = r_skip || i_icache_flush;

  assign w_clr = (i_icache_invalidate && !w_filling) ||
                 (w_last && (r_pend_inv || i_icache_invalidate));

  riscv_icache_data_array #(
    .LINES      (LINES),
    .LINE_BEATS (LINE_BEATS)
  ) u_array (
    .clk         (clk),
    .srst_n      (srst_n),
    .i_clr_valid (w_clr),
    .i_we        ((r_state == ST_REFILL) && i_mem_rvalid),
    .i_w_idx     (w_idx),
    .i_w_beat    (r_cnt),
    .i_w_data    (i_mem_rdata),
    .i_tag_we    (w_last),
    .i_w_tag     (w_tag),
    .i_r_idx     (w_idx),
    .i_r_beat    (w_beat),
    .o_r_data    (w_rdata),
    .o_r_tag     (w_rtag),
    .o_r_valid   (w_rvalid)
  );

  // Main controller; refill bookkeeping is updated first and overridden on the completion edge.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_pend_pc  <= '0;
      r_pend     <= 1'b0;
      r_skip     <= 1'b0;
      r_pend_inv <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_filling) begin
        r_pend    <= w_pend_nxt;
        r_pend_pc <= w_pend_pc_nxt;
        r_skip    <= w_skip_nxt;
        if (i_icache_invalidate) r_pend_inv <= 1'b1;
      end
      case (r_state)
        ST_IDLE, ST_RESPOND: begin
          if (w_take) begin
            r_pc    <= i_icache_pc[31:3];
            r_state <= ST_LOOKUP;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LOOKUP: begin
          if (w_take) begin
            r_pc    <= i_icache_pc[31:3];
            r_state <= ST_LOOKUP;
          end else if (w_hit || i_icache_flush) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_mem_gnt) begin
            r_cnt   <= '0;
            r_state <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (i_mem_rvalid) r_cnt <= r_cnt + BI_W'(1);
          if (w_last) begin
            r_pend     <= 1'b0;
            r_skip     <= 1'b0;
            r_pend_inv <= 1'b0;
            if (w_pend_nxt) begin
              r_pc    <= w_pend_pc_nxt;
              r_state <= ST_LOOKUP;
            end else if (w_skip_nxt) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_RESPOND;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
